// File: rtl/scan_scheduler.sv
// scan_scheduler: sequences the two-axis LDR sweep engine, supervises its
// trigger/status handshake with timeouts and retries, and drives the servo registers.
module scan_scheduler #(
  parameter int unsigned ANGLE_MAX    = 180,
  parameter int unsigned LDR_W        = 10,
  parameter int unsigned TRIG_CYCLES  = 2,
  parameter int unsigned ACK_TIMEOUT  = 64,
  parameter int unsigned SCAN_TIMEOUT = 2000000,
  parameter int unsigned MAX_RETRY    = 3,
  parameter int unsigned DROP_THRESH  = 32,
  parameter int unsigned DROP_CNT     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [31:0]      period,
  input  logic             force_scan,
  input  logic [31:0]      speed_cfg,
  output logic             scan_trigger,
  output logic [31:0]      scan_speed,
  input  logic             scan_status,
  input  logic [7:0]       scan_base,
  input  logic [7:0]       scan_arm,
  input  logic [LDR_W-1:0] ldr,
  output logic [7:0]       servo_base,
  output logic [7:0]       servo_arm,
  output logic [LDR_W-1:0] held_ldr,
  output logic             busy,
  output logic             fault,
  output logic [15:0]      scan_count
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_TRIG    = 3'd1;
  localparam logic [2:0] ST_ACK     = 3'd2;
  localparam logic [2:0] ST_RUN     = 3'd3;
  localparam logic [2:0] ST_CAPTURE = 3'd4;
  localparam logic [2:0] ST_HOLD    = 3'd5;
  localparam logic [2:0] ST_RETRY   = 3'd6;
  localparam logic [2:0] ST_FAULT   = 3'd7;

  logic [2:0]       state, state_nxt;
  logic [31:0]      tmr;
  logic [7:0]       retry_cnt;
  logic [15:0]      drop_cnt;
  logic             pending;
  logic [LDR_W:0]   ldr_plus;
  logic             drop_hit, drop_fire, period_hit, hold_exit;
  logic [7:0]       base_clamped, arm_clamped;

  // Drop compare is widened by one bit so ldr + DROP_THRESH cannot wrap.
  assign ldr_plus   = {1'b0, ldr} + (LDR_W+1)'(DROP_THRESH);
  assign drop_hit   = (DROP_THRESH != 0) && ({1'b0, held_ldr} > ldr_plus);
  assign drop_fire  = drop_hit && (drop_cnt == 16'(DROP_CNT - 1));
  assign period_hit = (period != '0) && (tmr >= period - 32'd1);
  assign hold_exit  = pending || force_scan || period_hit || drop_fire;

  assign base_clamped = (scan_base > 8'(ANGLE_MAX)) ? 8'(ANGLE_MAX) : scan_base;
  assign arm_clamped  = (scan_arm  > 8'(ANGLE_MAX)) ? 8'(ANGLE_MAX) : scan_arm;

  assign scan_trigger = (state == ST_TRIG);
  assign busy  = (state == ST_TRIG) || (state == ST_ACK) ||
                 (state == ST_RUN)  || (state == ST_CAPTURE);
  assign fault = (state == ST_FAULT);

  always_comb begin
    state_nxt = state;
    if (!enable) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:    state_nxt = ST_TRIG;
        ST_TRIG:    if (tmr == 32'(TRIG_CYCLES - 1)) state_nxt = ST_ACK;
        ST_ACK:     if (!scan_status) state_nxt = ST_RUN;
                    else if (tmr == 32'(ACK_TIMEOUT - 1)) state_nxt = ST_RETRY;
        ST_RUN:     if (scan_status) state_nxt = ST_CAPTURE;
                    else if (tmr == 32'(SCAN_TIMEOUT - 1)) state_nxt = ST_RETRY;
        ST_CAPTURE: state_nxt = ST_HOLD;
        ST_HOLD:    if (hold_exit) state_nxt = ST_TRIG;
        ST_RETRY:   state_nxt = (retry_cnt + 8'd1 >= 8'(MAX_RETRY)) ? ST_FAULT : ST_TRIG;
        ST_FAULT:   state_nxt = ST_FAULT;
        default:    state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      tmr        <= '0;
      retry_cnt  <= '0;
      drop_cnt   <= '0;
      pending    <= 1'b0;
      scan_speed <= '0;
      servo_base <= '0;
      servo_arm  <= '0;
      held_ldr   <= '0;
      scan_count <= '0;
    end else begin
      state <= state_nxt;
      // One shared timer: restarts on every state change, so it serves as
      // the TRIG width, both handshake timeouts and the HOLD period count.
      tmr <= (state_nxt != state) ? '0 : tmr + 32'd1;

      if (state_nxt == ST_TRIG && state != ST_TRIG)
        scan_speed <= speed_cfg;

      if (!enable || state == ST_HOLD)
        pending <= 1'b0;
      else if (force_scan && busy)
        pending <= 1'b1;

      if (!enable || state == ST_CAPTURE)
        retry_cnt <= '0;
      else if (state == ST_RETRY)
        retry_cnt <= retry_cnt + 8'd1;

      drop_cnt <= (state == ST_HOLD && drop_hit) ? drop_cnt + 16'd1 : '0;

      if (enable && (state == ST_ACK || state == ST_RUN)) begin
        servo_base <= scan_base;
        servo_arm  <= scan_arm;
      end else if (enable && state == ST_CAPTURE) begin
        servo_base <= base_clamped;
        servo_arm  <= arm_clamped;
        held_ldr   <= ldr;
        scan_count <= scan_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_scan_scheduler.sv
// Bench for scan_scheduler: stub sweep engine, directed and randomized stimulus,
// and a countdown-based behavioural model compared against the DUT every cycle.
module tb_scan_scheduler;

  localparam int LDR_W        = 10;
  localparam int ANGLE_MAX    = 180;
  localparam int TRIG_CYCLES  = 2;
  localparam int ACK_TIMEOUT  = 64;
  localparam int SCAN_TIMEOUT = 600;
  localparam int MAX_RETRY    = 3;
  localparam int DROP_THRESH  = 32;
  localparam int DROP_CNT     = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             enable = 1'b0;
  logic [31:0]      period = '0;
  logic             force_scan = 1'b0;
  logic [31:0]      speed_cfg = '0;
  logic             scan_trigger;
  logic [31:0]      scan_speed;
  logic             scan_status = 1'b1;
  logic [7:0]       scan_base = '0;
  logic [7:0]       scan_arm = '0;
  logic [LDR_W-1:0] ldr = 10'd600;
  logic [7:0]       servo_base, servo_arm;
  logic [LDR_W-1:0] held_ldr;
  logic             busy, fault;
  logic [15:0]      scan_count;

  scan_scheduler #(
    .ANGLE_MAX(ANGLE_MAX), .LDR_W(LDR_W), .TRIG_CYCLES(TRIG_CYCLES),
    .ACK_TIMEOUT(ACK_TIMEOUT), .SCAN_TIMEOUT(SCAN_TIMEOUT), .MAX_RETRY(MAX_RETRY),
    .DROP_THRESH(DROP_THRESH), .DROP_CNT(DROP_CNT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .period(period),
    .force_scan(force_scan), .speed_cfg(speed_cfg), .scan_trigger(scan_trigger),
    .scan_speed(scan_speed), .scan_status(scan_status), .scan_base(scan_base),
    .scan_arm(scan_arm), .ldr(ldr), .servo_base(servo_base), .servo_arm(servo_arm),
    .held_ldr(held_ldr), .busy(busy), .fault(fault), .scan_count(scan_count)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %0d, want %0d", name, cyc, act, exp);
    end
  endtask

  // ---------------- stub sweep engine ----------------
  logic       eng_mute = 1'b0;
  logic       eng_rand = 1'b0;
  int         eng_ack = 3;
  int         eng_run = 400;
  logic [7:0] eng_rb = 8'd97;
  logic [7:0] eng_ra = 8'd42;
  logic       eng_active = 1'b0;
  int         eng_t = 0;
  logic       eng_trig_d = 1'b0;

  initial forever begin
    @(negedge clk);
    if (scan_trigger && !eng_trig_d) begin
      logic go;
      go = !eng_mute;
      if (eng_rand) begin
        go      = ($urandom_range(99) >= 8);
        eng_ack = ($urandom_range(9) == 0) ? int'($urandom_range(60, 80)) : int'($urandom_range(1, 10));
        eng_run = ($urandom_range(19) == 0) ? 700 : int'($urandom_range(5, 150));
        eng_rb  = 8'($urandom);
        eng_ra  = 8'($urandom);
      end
      eng_active  = go;
      eng_t       = 0;
      scan_status = 1'b1;
    end else if (eng_active) begin
      eng_t++;
      if (eng_t == eng_ack) scan_status = 1'b0;
      if (eng_t > eng_ack && eng_t < eng_ack + eng_run) begin
        scan_base = 8'($urandom_range(0, 180));
        scan_arm  = 8'($urandom_range(0, 180));
      end
      if (eng_t == eng_ack + eng_run) begin
        scan_status = 1'b1;
        scan_base   = eng_rb;
        scan_arm    = eng_ra;
        eng_active  = 1'b0;
      end
    end
    eng_trig_d = scan_trigger;
  end

  // ---------------- behavioural model ----------------
  typedef enum {M_OFF, M_TRIG, M_WAITACK, M_SWEEP, M_CAPT, M_HOLD, M_RETRY, M_FAULT} mphase_t;
  mphase_t m_phase = M_OFF;
  longint  m_left = 0, m_hold_age = 0;
  int      m_attempts = 0, m_drop_run = 0, m_count = 0;
  bit      m_pend = 0;
  int      m_base = 0, m_arm = 0, m_held = 0;
  longint  m_speed = 0;

  function automatic bit m_busy();
    return m_phase inside {M_TRIG, M_WAITACK, M_SWEEP, M_CAPT};
  endfunction

  task automatic m_launch();
    m_phase = M_TRIG;
    m_left  = TRIG_CYCLES;
    m_speed = speed_cfg;
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_phase = M_OFF; m_left = 0; m_hold_age = 0; m_attempts = 0; m_drop_run = 0;
      m_count = 0; m_pend = 0; m_base = 0; m_arm = 0; m_held = 0; m_speed = 0;
    end else if (!enable) begin
      m_phase = M_OFF; m_pend = 0; m_attempts = 0;
    end else begin
      bit set_pend;
      set_pend = force_scan && m_busy();
      if (m_phase inside {M_WAITACK, M_SWEEP}) begin
        m_base = scan_base; m_arm = scan_arm;
      end
      case (m_phase)
        M_OFF:  m_launch();
        M_TRIG: begin
          m_left--;
          if (m_left == 0) begin m_phase = M_WAITACK; m_left = ACK_TIMEOUT; end
        end
        M_WAITACK:
          if (!scan_status) begin m_phase = M_SWEEP; m_left = SCAN_TIMEOUT; end
          else begin m_left--; if (m_left == 0) m_phase = M_RETRY; end
        M_SWEEP:
          if (scan_status) m_phase = M_CAPT;
          else begin m_left--; if (m_left == 0) m_phase = M_RETRY; end
        M_CAPT: begin
          m_base = (scan_base > ANGLE_MAX) ? ANGLE_MAX : int'(scan_base);
          m_arm  = (scan_arm  > ANGLE_MAX) ? ANGLE_MAX : int'(scan_arm);
          m_held = ldr;
          m_count = (m_count + 1) % 65536;
          m_attempts = 0; m_hold_age = 0; m_drop_run = 0;
          m_phase = M_HOLD;
        end
        M_HOLD: begin
          if (DROP_THRESH != 0 && (m_held - int'(ldr)) > DROP_THRESH) m_drop_run++;
          else m_drop_run = 0;
          if (m_pend || force_scan || m_drop_run >= DROP_CNT ||
              (period != 0 && m_hold_age + 1 >= longint'(period))) m_launch();
          else m_hold_age++;
          m_pend = 0;
        end
        M_RETRY: begin
          m_attempts++;
          if (m_attempts >= MAX_RETRY) m_phase = M_FAULT;
          else m_launch();
        end
        default: ;
      endcase
      if (set_pend) m_pend = 1;
    end
  end

  // ---------------- per-cycle compare and trigger monitor ----------------
  int   rise_q[$];
  int   hi_len = 0, last_hi = 0;
  logic mon_trig = 1'b0;

  initial forever begin
    @(negedge clk);
    cyc++;
    if (scan_trigger && !mon_trig) rise_q.push_back(cyc);
    if (scan_trigger) hi_len++;
    else begin
      if (hi_len != 0) last_hi = hi_len;
      hi_len = 0;
    end
    mon_trig = scan_trigger;
    vectors++;
    if (scan_trigger !== (m_phase == M_TRIG)) begin miscompares++; $display("FAIL trigger at cycle %0d: got %0d, want %0d", cyc, scan_trigger, m_phase == M_TRIG); end
    if (busy !== m_busy()) begin miscompares++; $display("FAIL busy at cycle %0d: got %0d, want %0d", cyc, busy, m_busy()); end
    if (fault !== (m_phase == M_FAULT)) begin miscompares++; $display("FAIL fault at cycle %0d: got %0d, want %0d", cyc, fault, m_phase == M_FAULT); end
    if (servo_base != m_base) begin miscompares++; $display("FAIL servo_base at cycle %0d: got %0d, want %0d", cyc, servo_base, m_base); end
    if (servo_arm != m_arm) begin miscompares++; $display("FAIL servo_arm at cycle %0d: got %0d, want %0d", cyc, servo_arm, m_arm); end
    if (held_ldr != m_held) begin miscompares++; $display("FAIL held_ldr at cycle %0d: got %0d, want %0d", cyc, held_ldr, m_held); end
    if (scan_count != m_count) begin miscompares++; $display("FAIL scan_count at cycle %0d: got %0d, want %0d", cyc, scan_count, m_count); end
    if (scan_speed != m_speed) begin miscompares++; $display("FAIL scan_speed at cycle %0d: got %0d, want %0d", cyc, scan_speed, m_speed); end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_force();
    @(negedge clk) force_scan = 1'b1;
    @(negedge clk) force_scan = 1'b0;
  endtask

  task automatic wait_count(input int target, input int budget, input string what);
    int k = 0;
    while (scan_count != 16'(target) && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(what, scan_count, target);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_trigger"}, scan_trigger, 0);
    chk({tag, "_speed"}, scan_speed, 0);
    chk({tag, "_servo_base"}, servo_base, 0);
    chk({tag, "_servo_arm"}, servo_arm, 0);
    chk({tag, "_held_ldr"}, held_ldr, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_fault"}, fault, 0);
    chk({tag, "_count"}, scan_count, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog at cycle %0d: got timeout, want finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r0, c0, k;
    speed_cfg = 32'h0000_1234;
    tick(3);
    chk_all_zero("reset");
    @(negedge clk); #2 rst_n = 1'b1;

    // Nominal scan
    @(negedge clk) enable = 1'b1;
    wait_count(1, 1000, "nominal_count");
    tick(20);
    chk("nominal_base", servo_base, 97);
    chk("nominal_arm", servo_arm, 42);
    chk("nominal_busy", busy, 0);
    chk("nominal_trig_len", last_hi, 2);
    chk("nominal_rises", rise_q.size(), 1);
    chk("nominal_speed", scan_speed, 32'h1234);
    chk("nominal_held", held_ldr, 600);
    chk("model_count_pin", m_count, 1);

    // Periodic scans
    period = 1000; eng_run = 100;
    wait_count(3, 4000, "periodic_count");
    period = 0;
    tick(50);
    chk("periodic_rises", rise_q.size(), 3);
    chk("periodic_gap", rise_q[2] - rise_q[1], 1105);

    // Ack timeout -> fault, then recovery
    eng_mute = 1'b1;
    r0 = rise_q.size();
    pulse_force();
    k = 0;
    while (!fault && k < 500) begin @(negedge clk); k++; end
    chk("acktmo_fault", fault, 1);
    chk("acktmo_rises", rise_q.size() - r0, 3);
    if (rise_q.size() >= r0 + 3) chk("acktmo_gap", rise_q[r0+2] - rise_q[r0+1], 67);
    eng_mute = 1'b0;
    tick(10);
    chk("fault_sticky", fault, 1);
    @(negedge clk) enable = 1'b0;
    @(negedge clk) enable = 1'b1;
    tick(1);
    chk("fault_cleared", fault, 0);
    chk("fault_retrigger", scan_trigger, 1);
    wait_count(4, 1000, "recover_count");

    // Clamp and drop detection
    eng_rb = 8'd200; eng_ra = 8'd45;
    pulse_force();
    wait_count(5, 1000, "clamp_count");
    chk("clamp_base", servo_base, 180);
    chk("clamp_arm", servo_arm, 45);
    chk("clamp_held", held_ldr, 600);
    r0 = rise_q.size();
    ldr = 10'd560; tick(16); ldr = 10'd600;
    tick(3);
    chk("drop16_rescan", rise_q.size() - r0, 1);
    wait_count(6, 1000, "drop_count");
    r0 = rise_q.size();
    ldr = 10'd570; tick(16); ldr = 10'd600;
    tick(5);
    chk("drop_thresh_edge", rise_q.size() - r0, 0);
    ldr = 10'd560; tick(15); ldr = 10'd600;
    tick(5);
    chk("drop15_no_rescan", rise_q.size() - r0, 0);

    // Pending request during RUN
    c0 = scan_count; r0 = rise_q.size();
    pulse_force();
    tick(30);
    pulse_force();
    tick(10);
    pulse_force();
    wait_count(c0 + 2, 2000, "pending_count");
    tick(50);
    chk("pending_rises", rise_q.size() - r0, 2);
    chk("pending_count_final", scan_count, c0 + 2);

    // Reset mid-RUN
    pulse_force();
    tick(30);
    #2 rst_n = 1'b0; enable = 1'b0;
    #1 chk_all_zero("midrun_reset");
    tick(3);
    #2 rst_n = 1'b1;
    tick(5);
    chk("post_reset_busy", busy, 0);
    @(negedge clk) enable = 1'b1;
    wait_count(1, 1000, "post_reset_count");

    // Randomized soak
    eng_rand = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      force_scan = ($urandom_range(99) < 3);
      enable     = ($urandom_range(999) >= 4);
      if ($urandom_range(199) == 0)
        period = ($urandom_range(3) == 0) ? 32'd0 : 32'($urandom_range(40, 300));
      if ($urandom_range(19) == 0) ldr = 10'($urandom_range(480, 720));
      speed_cfg = $urandom;
    end
    force_scan = 1'b0;
    enable = 1'b0;
    tick(5);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
